// File: rtl/img_row_loader_if.sv
// Bundle between img_row_loader (slave) and its environment (master):
// start pulse, pixel-row RAM read port, and the image vector valid/ack handshake.
interface img_row_loader_if #(
  parameter int unsigned ROWS = 28,
  parameter int unsigned COLS = 28
);
  localparam int unsigned AW = $clog2(ROWS);

  logic                 start;
  logic                 ram_rd_en;
  logic [AW-1:0]        ram_addr;
  logic [COLS-1:0]      ram_dout;
  logic [ROWS*COLS-1:0] x;
  logic                 x_valid;
  logic                 x_ack;
  logic                 busy;
  logic                 done;
  logic                 overrun;

  modport master (
    output start, ram_dout, x_ack,
    input  ram_rd_en, ram_addr, x, x_valid, busy, done, overrun
  );

  modport slave (
    input  start, ram_dout, x_ack,
    output ram_rd_en, ram_addr, x, x_valid, busy, done, overrun
  );
endinterface

// File: rtl/img_row_loader.sv
// Copies a ROWS x COLS image from the pixel-row RAM into a flat vector, one row per cycle.
// Define IMG_LOADER_SHADOW_EN to stage rows and keep x stable while a new image loads.
module img_row_loader #(
  parameter int unsigned ROWS   = 28,
  parameter int unsigned COLS   = 28,
  parameter int unsigned RD_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  img_row_loader_if.slave bus
);
  localparam int unsigned AW = $clog2(ROWS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]           r_state;
  logic [AW-1:0]        r_addr;
  logic [RD_LAT-1:0]    r_pv;
  logic [AW-1:0]        r_pt [RD_LAT];
  logic [ROWS*COLS-1:0] r_img;
  logic                 r_x_valid;
  logic                 r_done;
  logic                 r_overrun;

  logic [ROWS*COLS-1:0] w_img_next;
  logic                 w_rd_en;
  logic                 w_tail_clear;
  logic                 w_complete;
  logic                 w_ack;
  logic                 w_start_ok;
  logic                 w_drop;
  logic                 w_overwrite;

  assign w_rd_en    = (r_state == S_READ);
  assign w_complete = (r_state == S_DRAIN) && w_tail_clear;
  assign w_ack      = r_x_valid && bus.x_ack;
  assign w_drop     = bus.start && !w_start_ok;

`ifdef IMG_LOADER_SHADOW_EN
  logic [ROWS*COLS-1:0] r_x;

  assign w_start_ok  = bus.start && ((r_state == S_IDLE) || (r_state == S_HOLD));
  assign w_overwrite = w_complete && r_x_valid && !bus.x_ack;
  assign bus.x       = r_x;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x <= '0;
    end else if (w_complete) begin
      r_x <= w_img_next;
    end
  end
`else
  assign w_start_ok  = bus.start && (r_state == S_IDLE);
  assign w_overwrite = 1'b0;
  assign bus.x       = r_img;
`endif

  // Write the row whose tag reaches the pipeline tail together with its RAM data.
  always_comb begin
    w_img_next = r_img;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (r_pv[RD_LAT-1] && (r_pt[RD_LAT-1] == AW'(r))) begin
        w_img_next[(ROWS-r)*COLS-1 -: COLS] = bus.ram_dout;
      end
    end
  end

  // Empty after this edge once only the tail stage can still be valid.
  always_comb begin
    w_tail_clear = 1'b1;
    for (int unsigned k = 0; k + 1 < RD_LAT; k++) begin
      if (r_pv[k]) w_tail_clear = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_pv      <= '0;
      r_img     <= '0;
      r_x_valid <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_start_ok) begin
          r_state <= S_READ;
          r_addr  <= '0;
        end
        S_READ: begin
          if (r_addr == AW'(ROWS - 1)) begin
            r_state <= S_DRAIN;
            r_addr  <= '0;
          end else begin
            r_addr <= r_addr + AW'(1);
          end
        end
        S_DRAIN: if (w_tail_clear) r_state <= S_HOLD;
        S_HOLD: begin
          if (w_start_ok) begin
            r_state <= S_READ;
            r_addr  <= '0;
          end else if (w_ack) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      r_pv[0] <= w_rd_en;
      for (int unsigned k = 1; k < RD_LAT; k++) r_pv[k] <= r_pv[k-1];

      r_img <= w_img_next;

      if (w_complete) begin
        r_x_valid <= 1'b1;
      end else if (w_ack) begin
        r_x_valid <= 1'b0;
      end
      r_done    <= w_complete;
      r_overrun <= w_drop || w_overwrite;
    end
  end

  // Tags only matter where the matching valid bit is set, so they need no reset.
  always_ff @(posedge clk) begin
    r_pt[0] <= r_addr;
    for (int unsigned k = 1; k < RD_LAT; k++) r_pt[k] <= r_pt[k-1];
  end

  assign bus.ram_rd_en = w_rd_en;
  assign bus.ram_addr  = r_addr;
  assign bus.x_valid   = r_x_valid;
  assign bus.busy      = (r_state == S_READ) || (r_state == S_DRAIN);
  assign bus.done      = r_done;
  assign bus.overrun   = r_overrun;
endmodule

// File: tb/tb_img_row_loader.sv
// Directed bench for img_row_loader: 28x28/RD_LAT=2 and 4x8/RD_LAT=4 instances with RAM models.
module tb_img_row_loader;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  img_row_loader_if #(.ROWS(28), .COLS(28)) bus_a ();
  img_row_loader_if #(.ROWS(4),  .COLS(8))  bus_b ();

  img_row_loader #(.ROWS(28), .COLS(28), .RD_LAT(2)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  img_row_loader #(.ROWS(4),  .COLS(8),  .RD_LAT(4)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  logic [27:0] mem_a  [28];
  logic [27:0] pipe_a [2];
  logic [7:0]  mem_b  [4];
  logic [7:0]  pipe_b [4];

  // RAM models: data for the address presented in cycle c is on ram_dout in cycle c+RD_LAT.
  always @(posedge clk) begin
    pipe_a[0] <= mem_a[bus_a.ram_addr];
    pipe_a[1] <= pipe_a[0];
    pipe_b[0] <= mem_b[bus_b.ram_addr];
    for (int k = 1; k < 4; k++) pipe_b[k] <= pipe_b[k-1];
  end
  assign bus_a.ram_dout = pipe_a[1];
  assign bus_b.ram_dout = pipe_b[3];

  function automatic logic [783:0] img_a();
    logic [783:0] e;
    for (int r = 0; r < 28; r++) e[(28-r)*28-1 -: 28] = mem_a[r];
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulses start in the current cycle and advances to cycle 31 of the load.
  task automatic load_a();
    bus_a.start = 1'b1;
    for (int c = 1; c <= 31; c++) begin
      step();
      bus_a.start = 1'b0;
    end
  endtask

  task automatic ack_a();
    bus_a.x_ack = 1'b1;
    step();
    bus_a.x_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++;
    if ({bus_a.ram_rd_en, bus_a.busy, bus_a.x_valid, bus_a.done, bus_a.overrun} !== 5'b0
        || bus_a.ram_addr !== 5'd0 || bus_a.x !== 784'd0)
      begin n_fail++; $display("FAIL reset_a: ctl=%b addr=%0d", {bus_a.ram_rd_en, bus_a.busy,
        bus_a.x_valid, bus_a.done, bus_a.overrun}, bus_a.ram_addr); end
    n_checks++;
    if ({bus_b.ram_rd_en, bus_b.busy, bus_b.x_valid, bus_b.done, bus_b.overrun} !== 5'b0
        || bus_b.ram_addr !== 2'd0 || bus_b.x !== 32'd0)
      begin n_fail++; $display("FAIL reset_b: x=%h expected 0", bus_b.x); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_default_load();
    logic [3:0] got, exp;
    for (int r = 0; r < 28; r++) mem_a[r] = 28'h0000001 << r;
    bus_a.start = 1'b1;
    for (int c = 1; c <= 31; c++) begin
      step();
      bus_a.start = 1'b0;
      got = {bus_a.busy, bus_a.ram_rd_en, bus_a.x_valid, bus_a.done};
      exp = {c <= 30, c <= 28, c == 31, c == 31};
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL load_ctl cyc %0d: got %b expected %b", c, got, exp);
      end
      if (c <= 28) begin
        n_checks++;
        if (bus_a.ram_addr !== 5'(c - 1)) begin
          n_fail++; $display("FAIL load_addr cyc %0d: got %0d expected %0d", c, bus_a.ram_addr, c - 1);
        end
      end
    end
    n_checks++;
    if (bus_a.x[783:756] !== 28'h0000001 || bus_a.x[27:0] !== 28'h8000000) begin
      n_fail++; $display("FAIL load_ends: got %h/%h expected 0000001/8000000",
        bus_a.x[783:756], bus_a.x[27:0]);
    end
    n_checks++;
    if (bus_a.x !== img_a()) begin n_fail++; $display("FAIL load_x: got %h", bus_a.x); end
    step();
    n_checks++;
    if ({bus_a.x_valid, bus_a.done} !== 2'b10) begin
      n_fail++; $display("FAIL done_pulse: got %b expected 10", {bus_a.x_valid, bus_a.done});
    end
    ack_a();
    n_checks++;
    if ({bus_a.x_valid, bus_a.busy} !== 2'b00) begin
      n_fail++; $display("FAIL ack_clear: got %b expected 00", {bus_a.x_valid, bus_a.busy});
    end
  endtask

  task automatic test_small();
    logic [5:0] got, exp;
    mem_b[0] = 8'hA1; mem_b[1] = 8'hB2; mem_b[2] = 8'hC3; mem_b[3] = 8'hD4;
    bus_b.start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      bus_b.start = 1'b0;
      got = {bus_b.busy, bus_b.ram_rd_en, bus_b.x_valid, bus_b.done, bus_b.ram_addr};
      exp = {c <= 8, c <= 4, c == 9, c == 9, (c <= 4) ? 2'(c - 1) : 2'd0};
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL small_ctl cyc %0d: got %b expected %b", c, got, exp);
      end
    end
    n_checks++;
    if (bus_b.x !== 32'hA1B2C3D4) begin
      n_fail++; $display("FAIL small_x: got %h expected a1b2c3d4", bus_b.x);
    end
    bus_b.x_ack = 1'b1;
    step();
    bus_b.x_ack = 1'b0;
  endtask

  task automatic test_overrun_busy();
    for (int r = 0; r < 28; r++) mem_a[r] = 28'h5A00000 | 28'(r * 257);
    bus_a.start = 1'b1;
    for (int c = 1; c <= 31; c++) begin
      step();
      n_checks++;
      if ({bus_a.overrun, bus_a.x_valid} !== {c == 11, c == 31}) begin
        n_fail++; $display("FAIL busy_overrun cyc %0d: got %b expected %b", c,
          {bus_a.overrun, bus_a.x_valid}, {c == 11, c == 31});
      end
      bus_a.start = (c == 10);
    end
    n_checks++;
    if (bus_a.x !== img_a()) begin n_fail++; $display("FAIL overrun_x: got %h", bus_a.x); end
    ack_a();
  endtask

`ifndef IMG_LOADER_SHADOW_EN
  task automatic test_hold_noshadow();
    logic [783:0] old_x;
    for (int r = 0; r < 28; r++) mem_a[r] = ~(28'h0000001 << r);
    load_a();
    old_x = img_a();
    step();
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    n_checks++;
    if ({bus_a.overrun, bus_a.x_valid, bus_a.busy} !== 3'b110 || bus_a.x !== old_x) begin
      n_fail++; $display("FAIL hold_start: got %b expected 110",
        {bus_a.overrun, bus_a.x_valid, bus_a.busy});
    end
    step();
    bus_a.start = 1'b1;
    bus_a.x_ack = 1'b1;
    step();
    n_checks++;
    if ({bus_a.overrun, bus_a.x_valid, bus_a.busy} !== 3'b100) begin
      n_fail++; $display("FAIL ack_start: got %b expected 100",
        {bus_a.overrun, bus_a.x_valid, bus_a.busy});
    end
    // Stale ack in IDLE alongside a start must not disturb the load.
    for (int r = 0; r < 28; r++) mem_a[r] = 28'(r * 9973);
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    bus_a.x_ack = 1'b0;
    for (int c = 2; c <= 31; c++) step();
    n_checks++;
    if ({bus_a.x_valid, bus_a.done} !== 2'b11 || bus_a.x !== img_a()) begin
      n_fail++; $display("FAIL reload: got %b x=%h", {bus_a.x_valid, bus_a.done}, bus_a.x);
    end
    ack_a();
  endtask
`else
  task automatic test_shadow();
    logic [783:0] old_x;
    for (int r = 0; r < 28; r++) mem_a[r] = 28'h1234567 ^ 28'(r);
    load_a();
    old_x = img_a();
    for (int r = 0; r < 28; r++) mem_a[r] = 28'hFEDCBA9 - 28'(r);
    bus_a.start = 1'b1;
    for (int c = 1; c <= 31; c++) begin
      step();
      bus_a.start = 1'b0;
      if (c < 31) begin
        n_checks++;
        if (bus_a.x !== old_x || {bus_a.x_valid, bus_a.done, bus_a.overrun} !== 3'b100) begin
          n_fail++; $display("FAIL shadow_stable cyc %0d: got %b", c,
            {bus_a.x_valid, bus_a.done, bus_a.overrun});
        end
      end
    end
    n_checks++;
    if (bus_a.x !== img_a() || {bus_a.x_valid, bus_a.done, bus_a.overrun} !== 3'b111) begin
      n_fail++; $display("FAIL shadow_overwrite: got %b expected 111",
        {bus_a.x_valid, bus_a.done, bus_a.overrun});
    end
    for (int r = 0; r < 28; r++) mem_a[r] = 28'(r * 31337);
    bus_a.start = 1'b1;
    for (int c = 1; c <= 31; c++) begin
      step();
      bus_a.start = 1'b0;
      bus_a.x_ack = (c == 30);
    end
    n_checks++;
    if (bus_a.x !== img_a() || {bus_a.x_valid, bus_a.done, bus_a.overrun} !== 3'b110) begin
      n_fail++; $display("FAIL shadow_ack_done: got %b expected 110",
        {bus_a.x_valid, bus_a.done, bus_a.overrun});
    end
    ack_a();
    n_checks++;
    if (bus_a.x_valid !== 1'b0) begin
      n_fail++; $display("FAIL shadow_ack: got %b expected 0", bus_a.x_valid);
    end
  endtask
`endif

  task automatic test_reset_mid();
    bus_a.start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      step();
      bus_a.start = 1'b0;
      rst = (c == 15);
    end
    n_checks++;
    if ({bus_a.ram_rd_en, bus_a.busy, bus_a.x_valid, bus_a.done, bus_a.overrun} !== 5'b0
        || bus_a.ram_addr !== 5'd0 || bus_a.x !== 784'd0) begin
      n_fail++; $display("FAIL mid_reset: ctl=%b addr=%0d expected 0", {bus_a.ram_rd_en,
        bus_a.busy, bus_a.x_valid, bus_a.done, bus_a.overrun}, bus_a.ram_addr);
    end
    rst = 1'b0;
    step();
    for (int r = 0; r < 28; r++) mem_a[r] = 28'hC0FFEE0 + 28'(r);
    load_a();
    n_checks++;
    if ({bus_a.x_valid, bus_a.done} !== 2'b11 || bus_a.x !== img_a()) begin
      n_fail++; $display("FAIL post_reset_load: got %b x=%h", {bus_a.x_valid, bus_a.done},
        bus_a.x);
    end
    ack_a();
  endtask

  initial begin
    rst         = 1'b1;
    bus_a.start = 1'b0;
    bus_a.x_ack = 1'b0;
    bus_b.start = 1'b0;
    bus_b.x_ack = 1'b0;
    for (int r = 0; r < 28; r++) mem_a[r] = '0;
    for (int r = 0; r < 4; r++) mem_b[r] = '0;
    test_reset();
    test_default_load();
    test_small();
    test_overrun_busy();
`ifndef IMG_LOADER_SHADOW_EN
    test_hold_noshadow();
`else
    test_shadow();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
